// File: rtl/oled_game_pkg.sv
// rtl/oled_game_pkg.sv - shared round-FSM encodings and 7-segment digit patterns
package oled_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_FLUSH,
    ST_ENTRY,
    ST_CHECK,
    ST_SHOW,
    ST_DONE
  } round_state_t;

  localparam int PRIME_CYCLES = 2;
  localparam int FLUSH_CYCLES = 2;

  // Segment order {g,f,e,d,c,b,a}, shared with the entry grid
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = SEG_0;
      4'd1:    seg_pattern = SEG_1;
      4'd2:    seg_pattern = SEG_2;
      4'd3:    seg_pattern = SEG_3;
      4'd4:    seg_pattern = SEG_4;
      4'd5:    seg_pattern = SEG_5;
      4'd6:    seg_pattern = SEG_6;
      4'd7:    seg_pattern = SEG_7;
      4'd8:    seg_pattern = SEG_8;
      4'd9:    seg_pattern = SEG_9;
      default: seg_pattern = 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] fold_digit(input logic [3:0] n);
    return (n >= 4'd10) ? n - 4'd10 : n;
  endfunction

endpackage

// File: rtl/digit_round_ctrl_if.sv
// rtl/digit_round_ctrl_if.sv - round controller signals between grid datapath and display
interface digit_round_ctrl_if;
  logic       start;
  logic       confirm;
  logic       is_valid;
  logic [3:0] valid_number;
  logic       entry_enable;
  logic [3:0] target;
  logic [3:0] secs_left;
  logic [6:0] score;
  logic [3:0] rounds_left;
  logic       result_correct;
  logic       result_wrong;
  logic       busy;
  logic       done;

  modport master (
    output start, confirm, is_valid, valid_number,
    input  entry_enable, target, secs_left, score, rounds_left,
    input  result_correct, result_wrong, busy, done
  );

  modport slave (
    input  start, confirm, is_valid, valid_number,
    output entry_enable, target, secs_left, score, rounds_left,
    output result_correct, result_wrong, busy, done
  );
endinterface

// File: rtl/digit_lfsr.sv
// rtl/digit_lfsr.sv - free-running 8-bit LFSR folded to a decimal digit
module digit_lfsr
  import oled_game_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [3:0] digit
);

  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, maximal length so a non-zero seed never reaches 0
  always_ff @(posedge clock) begin
    if (reset) lfsr <= seed;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign digit = fold_digit(lfsr[3:0]);

endmodule

// File: rtl/digit_round_ctrl.sv
// rtl/digit_round_ctrl.sv - sequences timed draw-the-digit rounds and scores entries
module digit_round_ctrl
  import oled_game_pkg::*;
#(
  parameter int         TICKS_PER_SEC = 100_000_000,
  parameter int         ROUND_SECONDS = 10,
  parameter int         SHOW_CYCLES   = 50_000_000,
  parameter int         ROUNDS        = 5,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input logic              clock,
  input logic              reset,
  digit_round_ctrl_if.slave bus
);

  localparam int TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int PHASE_MAX = (SHOW_CYCLES > 2) ? SHOW_CYCLES : 2;
  localparam int PHASE_W   = $clog2(PHASE_MAX);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [PHASE_W-1:0] PRIME_LAST = PHASE_W'(PRIME_CYCLES - 1);
  localparam logic [PHASE_W-1:0] FLUSH_LAST = PHASE_W'(FLUSH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] SHOW_LAST  = PHASE_W'(SHOW_CYCLES - 1);

  round_state_t        state, state_n;
  logic [PHASE_W-1:0]  phase;
  logic [TICK_W-1:0]   tick;
  logic [3:0]          target_q, secs_q, rounds_q;
  logic [6:0]          score_q;
  logic                correct_q, wrong_q;
  logic [3:0]          digit;
  logic                wrap, entry_en;
  logic                begin_game, arm_round, grade, timeout, end_round;

  digit_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .digit (digit)
  );

  assign wrap = (tick == TICK_LAST);

  always_comb begin
    state_n    = state;
    entry_en   = 1'b0;
    begin_game = 1'b0;
    arm_round  = 1'b0;
    grade      = 1'b0;
    timeout    = 1'b0;
    end_round  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_n    = ST_PRIME;
          begin_game = 1'b1;
        end
      end
      ST_PRIME: begin
        entry_en = 1'b1;
        if (phase == PRIME_LAST) state_n = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (phase == FLUSH_LAST) begin
          state_n   = ST_ENTRY;
          arm_round = 1'b1;
        end
      end
      ST_ENTRY: begin
        entry_en = 1'b1;
        // A valid entry beats a timeout landing on the same cycle
        if (bus.confirm && bus.is_valid) begin
          state_n = ST_CHECK;
        end else if (wrap && secs_q == 4'd1) begin
          state_n = ST_SHOW;
          timeout = 1'b1;
        end
      end
      ST_CHECK: begin
        grade   = 1'b1;
        state_n = ST_SHOW;
      end
      ST_SHOW: begin
        if (phase == SHOW_LAST) begin
          end_round = 1'b1;
          state_n   = (rounds_q == 4'd1) ? ST_DONE : ST_PRIME;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase     <= '0;
      tick      <= '0;
      target_q  <= '0;
      secs_q    <= '0;
      rounds_q  <= '0;
      score_q   <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
    end else begin
      state <= state_n;
      phase <= (state_n != state) ? '0 : phase + 1'b1;
      if (state == ST_ENTRY) begin
        tick <= wrap ? '0 : tick + 1'b1;
        if (wrap) secs_q <= secs_q - 4'd1;
      end
      if (arm_round) begin
        secs_q <= 4'(ROUND_SECONDS);
        tick   <= '0;
      end
      if (begin_game) begin
        score_q  <= '0;
        rounds_q <= 4'(ROUNDS);
        target_q <= digit;
      end
      if (grade) begin
        if (bus.valid_number == target_q) begin
          correct_q <= 1'b1;
          if (score_q != 7'd99) score_q <= score_q + 7'd1;
        end else begin
          wrong_q <= 1'b1;
        end
      end
      if (timeout) wrong_q <= 1'b1;
      if (end_round) begin
        correct_q <= 1'b0;
        wrong_q   <= 1'b0;
        rounds_q  <= rounds_q - 4'd1;
        if (rounds_q != 4'd1) target_q <= digit;
      end
    end
  end

  assign bus.entry_enable   = entry_en;
  assign bus.target         = target_q;
  assign bus.secs_left      = secs_q;
  assign bus.score          = score_q;
  assign bus.rounds_left    = rounds_q;
  assign bus.result_correct = correct_q;
  assign bus.result_wrong   = wrong_q;
  assign bus.busy           = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done           = (state == ST_DONE);

endmodule

// File: tb/tb_digit_round_ctrl.sv
// tb/tb_digit_round_ctrl.sv - randomized game-level check of digit_round_ctrl
module tb_digit_round_ctrl;

  localparam int T  = 4;
  localparam int RS = 3;
  localparam int SC = 5;
  localparam int NR = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  digit_round_ctrl_if bus();

  digit_round_ctrl #(
    .TICKS_PER_SEC (T),
    .ROUND_SECONDS (RS),
    .SHOW_CYCLES   (SC),
    .ROUNDS        (NR),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  int         exp_score = 0;
  int         exp_rounds = 0;
  int         n_targets = 0;
  logic [9:0] seen = '0;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] outs();
    return {bus.entry_enable, bus.target, bus.secs_left, bus.score, bus.rounds_left,
            bus.result_correct, bus.result_wrong, bus.busy, bus.done};
  endfunction

  task automatic start_game();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exp_score  = 0;
    exp_rounds = NR;
    check("start_score", bus.score, 0);
    check("start_rounds", bus.rounds_left, NR);
    check("start_busy", bus.busy, 1);
    check("start_done", bus.done, 0);
  endtask

  task automatic to_entry();
    int n = 0;
    while (bus.entry_enable !== 1'b1 && n < 40) begin step(); n++; end
    while (bus.entry_enable !== 1'b0 && n < 40) begin step(); n++; end
    while (bus.entry_enable !== 1'b1 && n < 40) begin step(); n++; end
    check("reach_entry", n < 40, 1);
  endtask

  // mode 0 correct, 1 wrong digit, 2 timeout, 3 invalid confirm then wrong digit
  task automatic play_round(input int mode, input int when, input bit rst_show);
    logic [3:0] tgt;
    bit         confirmed = 1'b0;
    bit         exp_c = 1'b0;
    int         num;
    tgt = bus.target;
    check("target_range", tgt <= 4'd9, 1);
    if (tgt <= 4'd9) seen[tgt] = 1'b1;
    n_targets++;
    check("rounds_at_entry", bus.rounds_left, exp_rounds);
    check("score_at_entry", bus.score, exp_score);
    for (int k = 0; k < RS * T && !confirmed; k++) begin
      check("secs_left", bus.secs_left, RS - k / T);
      check("entry_enable", bus.entry_enable, 1);
      check("flags_in_entry", {bus.result_correct, bus.result_wrong}, 0);
      if ($urandom_range(3) == 0) bus.start = 1'b1;
      if (k == when && mode == 3) begin
        bus.confirm = 1'b1; bus.is_valid = 1'b0; bus.valid_number = tgt;
      end else if ((k == when && (mode == 0 || mode == 1)) || (k == when + 1 && mode == 3)) begin
        num = (mode == 0) ? int'(tgt) : (int'(tgt) + 1 + int'($urandom_range(8))) % 10;
        bus.confirm = 1'b1; bus.is_valid = 1'b1; bus.valid_number = num[3:0];
        exp_c = (num == int'(tgt));
        confirmed = 1'b1;
      end
      step();
      bus.start = 1'b0; bus.confirm = 1'b0; bus.is_valid = 1'b0;
    end
    if (confirmed) begin
      check("check_ee", bus.entry_enable, 0);
      check("check_flags", {bus.result_correct, bus.result_wrong}, 0);
      step();
    end else begin
      check("timeout_secs", bus.secs_left, 0);
    end
    if (exp_c && exp_score < 99) exp_score++;
    for (int j = 0; j < SC; j++) begin
      check("result_correct", bus.result_correct, exp_c);
      check("result_wrong", bus.result_wrong, !exp_c);
      check("show_score", bus.score, exp_score);
      check("show_ee", bus.entry_enable, 0);
      check("show_busy", bus.busy, 1);
      if (rst_show && j == 2) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_in_show", outs(), 0);
        step();
        check("idle_after_reset", outs(), 0);
        return;
      end
      if (j == 1) begin
        bus.confirm = 1'b1; bus.is_valid = 1'b1; bus.valid_number = tgt;
      end
      step();
      bus.confirm = 1'b0; bus.is_valid = 1'b0;
    end
    exp_rounds--;
    check("flags_cleared", {bus.result_correct, bus.result_wrong}, 0);
    check("rounds_after", bus.rounds_left, exp_rounds);
    check("done_after", bus.done, exp_rounds == 0);
    check("busy_after", bus.busy, exp_rounds != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] hold_tgt;
    int         m;
    bus.start = 1'b0; bus.confirm = 1'b0; bus.is_valid = 1'b0; bus.valid_number = '0;
    reset = 1'b1;
    repeat (3) step();
    check("reset_outputs", outs(), 0);
    reset = 1'b0;
    repeat (3) step();
    check("idle_hold", outs(), 0);

    start_game();
    check("prime_ee0", bus.entry_enable, 1);
    step(); check("prime_ee1", bus.entry_enable, 1);
    step(); check("flush_ee0", bus.entry_enable, 0);
    step(); check("flush_ee1", bus.entry_enable, 0);
    step(); check("entry_ee", bus.entry_enable, 1);
    play_round(0, 2, 1'b0);
    to_entry(); play_round(2, -1, 1'b0);
    to_entry(); play_round(3, 1, 1'b0);

    hold_tgt = bus.target;
    repeat (4) step();
    check("done_target_stable", bus.target, hold_tgt);
    check("done_score_stable", bus.score, exp_score);
    check("done_rounds", bus.rounds_left, 0);
    check("done_level", bus.done, 1);

    start_game();
    to_entry(); play_round(0, RS * T - 1, 1'b0);
    to_entry(); play_round(1, 5, 1'b0);
    to_entry(); play_round(0, 3, 1'b1);

    while (n_targets < 1000) begin
      start_game();
      for (int r = 0; r < NR; r++) begin
        m = int'($urandom_range(9));
        to_entry();
        play_round((m <= 5) ? 0 : (m <= 7) ? 1 : (m == 8) ? 3 : 2,
                   int'($urandom_range(10)), 1'b0);
      end
    end
    check("all_digits_seen", seen, 10'h3FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
